pipe_hazard_ctrl: RTL and testbench

//  Front-end sequencer for the 5-stage pipeline. Drives PCWrite, the IF/ID register write enable (IFWrite),
//  the IF/ID flush, and the ID/EX bubble.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 102 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings and constants for the front-end hazard sequencer.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_W   = 5;
    localparam int unsigned STATE_W = 2;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'b00,
        ST_MDWAIT = 2'b01
    } state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: load in EX writes a register the instruction in ID reads.
module hazard_detect
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_Rt,
    input  logic [REG_W-1:0] ID_Rs,
    input  logic [REG_W-1:0] ID_Rt,
    input  logic             ID_UsesRt,
    output logic             Load_Use
);

    // $zero is never a real dependency, so a load targeting it never stalls
    assign Load_Use = EX_MemRead && (EX_Rt != REG_ZERO) &&
                      ((EX_Rt == ID_Rs) || (ID_UsesRt && (EX_Rt == ID_Rt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Front-end sequencer: PC/IF-ID enables, IF/ID flush, ID/EX bubble, stall counter.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MD_LATENCY = 32,
    parameter int unsigned CNT_W      = 6,
    parameter int unsigned PERF_W     = 32
)
(
    input  logic                clk,
    input  logic                Reset_L,
    input  logic [REG_W-1:0]    ID_Rs,
    input  logic [REG_W-1:0]    ID_Rt,
    input  logic                ID_UsesRt,
    input  logic                EX_MemRead,
    input  logic [REG_W-1:0]    EX_Rt,
    input  logic                MD_Start,
    input  logic                IM_Ready,
    input  logic                Branch_Taken,
    input  logic                Stall_Cnt_Clr,
    output logic                PCWrite,
    output logic                IFWrite,
    output logic                IF_Flush,
    output logic                ID_Bubble,
    output logic [STATE_W-1:0]  State,
    output logic [PERF_W-1:0]   Stall_Cnt
);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    md_cnt_q, md_cnt_d;
    logic [PERF_W-1:0]   stall_cnt_q;
    logic                load_use;

    hazard_detect u_hazard_detect (
        .EX_MemRead (EX_MemRead),
        .EX_Rt      (EX_Rt),
        .ID_Rs      (ID_Rs),
        .ID_Rt      (ID_Rt),
        .ID_UsesRt  (ID_UsesRt),
        .Load_Use   (load_use)
    );

    // State and mult/div countdown registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!Reset_L) begin
            state_q  <= ST_RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    // Next-state and zero-latency control outputs; unknown encodings behave as RUN
    always_comb begin
        state_d   = state_q;
        md_cnt_d  = md_cnt_q;
        PCWrite   = 1'b0;
        IFWrite   = 1'b0;
        IF_Flush  = 1'b0;
        ID_Bubble = 1'b0;
        if (Reset_L) begin
            case (state_q)
                ST_MDWAIT: begin
                    ID_Bubble = 1'b1;
                    if (md_cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        md_cnt_d = md_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    if (!IM_Ready || load_use) begin
                        // stalled: a pending branch or mult/div re-resolves later
                        ID_Bubble = 1'b1;
                    end else begin
                        PCWrite  = 1'b1;
                        IFWrite  = 1'b1;
                        IF_Flush = Branch_Taken;
                        if (MD_Start) begin
                            state_d  = ST_MDWAIT;
                            md_cnt_d = CNT_W'(MD_LATENCY - 1);
                        end
                    end
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held
    always_ff @(posedge clk) begin
        if (!Reset_L || Stall_Cnt_Clr) begin
            stall_cnt_q <= '0;
        end else if (!PCWrite && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + PERF_W'(1);
        end
    end

    assign State     = state_q;
    assign Stall_Cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed check of pipe_hazard_ctrl against a cycle-count reference model.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_l;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_uses_rt, ex_mem_read, md_start, im_ready, br_taken, cnt_clr;

    logic       pcw_a, ifw_a, flush_a, bub_a;
    logic [1:0] st_a;
    logic [3:0] cnt_a;
    logic       pcw_b, ifw_b, flush_b, bub_b;
    logic [1:0] st_b;
    logic [7:0] cnt_b;

    logic [3:0] ctl_obs [2];
    logic [1:0] st_obs  [2];
    logic [7:0] cnt_obs [2];

    int n_total = 0;
    int n_bad   = 0;

    // reference model: remaining wait cycles and stall count per instance
    int lat  [2] = '{4, 1};
    int maxc [2] = '{15, 255};
    int left [2] = '{0, 0};
    int scnt [2] = '{0, 0};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(4), .CNT_W(2), .PERF_W(4)) u_dut_a (
        .clk(clk), .Reset_L(rst_l), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
        .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .MD_Start(md_start), .IM_Ready(im_ready),
        .Branch_Taken(br_taken), .Stall_Cnt_Clr(cnt_clr), .PCWrite(pcw_a), .IFWrite(ifw_a),
        .IF_Flush(flush_a), .ID_Bubble(bub_a), .State(st_a), .Stall_Cnt(cnt_a)
    );

    pipe_hazard_ctrl #(.MD_LATENCY(1), .CNT_W(1), .PERF_W(8)) u_dut_b (
        .clk(clk), .Reset_L(rst_l), .ID_Rs(id_rs), .ID_Rt(id_rt), .ID_UsesRt(id_uses_rt),
        .EX_MemRead(ex_mem_read), .EX_Rt(ex_rt), .MD_Start(md_start), .IM_Ready(im_ready),
        .Branch_Taken(br_taken), .Stall_Cnt_Clr(cnt_clr), .PCWrite(pcw_b), .IFWrite(ifw_b),
        .IF_Flush(flush_b), .ID_Bubble(bub_b), .State(st_b), .Stall_Cnt(cnt_b)
    );

    assign ctl_obs[0] = {pcw_a, ifw_a, flush_a, bub_a};
    assign ctl_obs[1] = {pcw_b, ifw_b, flush_b, bub_b};
    assign st_obs[0]  = st_a;
    assign st_obs[1]  = st_b;
    assign cnt_obs[0] = {4'b0000, cnt_a};
    assign cnt_obs[1] = cnt_b;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_lu();
        if (!ex_mem_read || ex_rt == 5'd0) return 1'b0;
        return (ex_rt == id_rs) || (id_uses_rt && ex_rt == id_rt);
    endfunction

    // expected {PCWrite, IFWrite, IF_Flush, ID_Bubble}
    function automatic logic [3:0] model_ctl(input int i, input logic lu);
        if (!rst_l)                 return 4'b0000;
        if (left[i] > 0)            return 4'b0001;
        if (!im_ready || lu)        return 4'b0001;
        return {2'b11, br_taken, 1'b0};
    endfunction

    // one clock: check outputs mid-cycle, advance model, let the DUT clock
    task automatic cycle();
        logic       lu;
        logic [3:0] e;
        @(negedge clk);
        #1;
        lu = model_lu();
        for (int i = 0; i < 2; i++) begin
            e = model_ctl(i, lu);
            chk($sformatf("ctl%0d", i), 32'(ctl_obs[i]), 32'(e));
            chk($sformatf("state%0d", i), 32'(st_obs[i]), (left[i] > 0) ? 32'd1 : 32'd0);
            chk($sformatf("scnt%0d", i), 32'(cnt_obs[i]), 32'(scnt[i]));
            if (!rst_l) begin
                left[i] = 0;
                scnt[i] = 0;
            end else begin
                if (cnt_clr)                         scnt[i] = 0;
                else if (!e[3] && scnt[i] < maxc[i]) scnt[i]++;
                if (left[i] > 0)                     left[i]--;
                else if (md_start && e[3])           left[i] = lat[i];
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_l = 1'b1; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0; id_uses_rt = 1'b0;
        ex_mem_read = 1'b0; md_start = 1'b0; im_ready = 1'b1; br_taken = 1'b0; cnt_clr = 1'b0;
    endtask

    task automatic clear_cnt();
        idle();
        cnt_clr = 1'b1;
        cycle();
        cnt_clr = 1'b0;
    endtask

    initial begin
        // reset with every input high
        rst_l = 1'b0; id_rs = 5'h1f; id_rt = 5'h1f; ex_rt = 5'h1f; id_uses_rt = 1'b1;
        ex_mem_read = 1'b1; md_start = 1'b1; im_ready = 1'b1; br_taken = 1'b1; cnt_clr = 1'b1;
        cycle();
        chk("rst_ctl", 32'(ctl_obs[0]), 32'd0);
        cycle();
        idle();
        cycle();
        chk("rst_state", 32'(st_obs[0]), 32'd0);
        chk("rst_cnt", 32'(cnt_obs[0]), 32'd0);

        // load-use on rs, then the same load targeting $zero
        ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
        cycle();
        idle();
        cycle();
        chk("lu_cnt", 32'(cnt_obs[0]), 32'd1);
        ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cycle();
        chk("lu_zero_cnt", 32'(cnt_obs[0]), 32'd1);

        // mult/div occupancy
        clear_cnt();
        md_start = 1'b1;
        cycle();
        md_start = 1'b0;
        repeat (5) cycle();
        chk("md_cnt", 32'(cnt_obs[0]), 32'd4);
        chk("md_state", 32'(st_obs[0]), 32'd0);

        // reset in the second wait cycle abandons the wait
        md_start = 1'b1;
        cycle();
        md_start = 1'b0;
        cycle();
        rst_l = 1'b0;
        cycle();
        chk("md_rst_state", 32'(st_obs[0]), 32'd0);
        rst_l = 1'b1;
        cycle();

        // taken branch: clean, behind a load-use, behind a fetch miss
        idle(); br_taken = 1'b1;
        cycle();
        ex_mem_read = 1'b1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        cycle();
        idle(); br_taken = 1'b1; im_ready = 1'b0;
        cycle();

        // mult/div ignored during fetch misses
        clear_cnt();
        md_start = 1'b1; im_ready = 1'b0;
        repeat (3) cycle();
        chk("imr_state", 32'(st_obs[0]), 32'd0);
        chk("imr_cnt", 32'(cnt_obs[0]), 32'd3);

        // saturation and clear during a stall
        clear_cnt();
        im_ready = 1'b0;
        repeat (20) cycle();
        chk("sat_a", 32'(cnt_obs[0]), 32'hf);
        chk("sat_b", 32'(cnt_obs[1]), 32'd20);
        cnt_clr = 1'b1;
        cycle();
        chk("clr_stall", 32'(cnt_obs[0]), 32'd0);

        // random traffic with small register numbers to provoke matches
        idle();
        for (int n = 0; n < 2000; n++) begin
            rst_l       = ($urandom_range(0, 99) >= 3);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ex_rt       = 5'($urandom_range(0, 3));
            id_uses_rt  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            md_start    = ($urandom_range(0, 99) < 15);
            im_ready    = ($urandom_range(0, 99) < 80);
            br_taken    = ($urandom_range(0, 99) < 30);
            cnt_clr     = ($urandom_range(0, 99) < 3);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
